sr_config_loader: RTL and testbench

- Upstream feeder for the shift-register read/write block.
- Pops NWORDS 16-bit configuration words from the control-interface command FIFO and presents each as a one-cycle write strobe (sr_wr_en/sr_din).
- Then issues a start pulse long enough to be sampled by the divided SR clock, and waits for the readback valid from the SR block or a timeout.
- Gives software a single go/done/timeout handshake for one full shift-register transaction.

---
 rtl/sr_config_loader_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/sr_config_loader.sv | 129 ++++++++++++
 tb/tb_sr_config_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_config_loader_pkg.sv
// rtl/sr_config_loader_pkg.sv - shared state encoding and sizing helper for the SR config loader
package sr_config_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        START,
        WAIT,
        DONE
    } state_t;

    function automatic int calc_nwords(input int width, input int word_width);
        return (width + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with a one-cycle rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/sr_config_loader.sv
// rtl/sr_config_loader.sv - pops config words from the command FIFO, strobes them into the SR block, starts it and waits for readback
module sr_config_loader
    import sr_config_loader_pkg::*;
#(
    parameter int WIDTH         = 170,
    parameter int WORD_WIDTH    = 16,
    parameter int NWORDS        = calc_nwords(WIDTH, WORD_WIDTH),
    parameter int DIV_WIDTH     = 6,
    parameter int HOLD_WIDTH    = 32,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  abort,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [WORD_WIDTH-1:0] cmd_fifo_dout,
    input  logic                  cmd_fifo_empty,
    output logic                  cmd_fifo_rd_en,
    output logic                  sr_wr_en,
    output logic [WORD_WIDTH-1:0] sr_din,
    output logic                  sr_start,
    input  logic                  sr_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam int CNT_W = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    // to_cnt is about to become all-ones: exit on this cycle
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    state_t                   state;
    state_t                   state_n;
    logic [DIV_WIDTH-1:0]     div_q;
    logic [CNT_W-1:0]         word_cnt;
    logic [HOLD_WIDTH-1:0]    hold_cnt;
    logic [HOLD_WIDTH-1:0]    hold_limit;
    logic [TIMEOUT_WIDTH-1:0] to_cnt;
    logic [WORD_WIDTH-1:0]    din_q;
    logic                     valid_rise;

    sync_edge_detect u_valid_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sr_valid),
        .rise (valid_rise)
    );

    // Start must span a full divided-clock period so the SR block samples it
    always_comb begin
        hold_limit = '1;
        if (int'(div_q) + 1 < HOLD_WIDTH) begin
            hold_limit = (HOLD_WIDTH'(1) << (int'(div_q) + 1)) - 1'b1;
        end
    end

    always_comb begin
        state_n        = state;
        cmd_fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_n = FETCH;
            end
            FETCH: begin
                if (!cmd_fifo_empty) begin
                    cmd_fifo_rd_en = 1'b1;
                    state_n        = CAPTURE;
                end
            end
            CAPTURE: begin
                state_n = (word_cnt == LAST_WORD) ? START : FETCH;
            end
            START: begin
                if (hold_cnt == hold_limit) state_n = WAIT;
            end
            WAIT: begin
                if (valid_rise || to_cnt == TO_LAST) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort && state != IDLE) begin
            state_n        = IDLE;
            cmd_fifo_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_q    <= '0;
            word_cnt <= '0;
            hold_cnt <= '0;
            to_cnt   <= '0;
            din_q    <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= (state == START) ? hold_cnt + 1'b1 : '0;
            to_cnt   <= (state == WAIT) ? to_cnt + 1'b1 : '0;
            if (state == IDLE && go) begin
                div_q    <= div;
                word_cnt <= '0;
                timeout  <= 1'b0;
            end
            if (state == CAPTURE) begin
                din_q    <= cmd_fifo_dout;
                word_cnt <= word_cnt + 1'b1;
            end
            if (state == WAIT && !abort && !valid_rise && to_cnt == TO_LAST) begin
                timeout <= 1'b1;
            end
        end
    end

    // The FIFO word is presented combinationally so data and strobe share the CAPTURE cycle
    assign sr_din   = (state == CAPTURE) ? cmd_fifo_dout : din_q;
    assign sr_wr_en = (state == CAPTURE);
    assign sr_start = (state == START);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_sr_config_loader.sv
// tb/tb_sr_config_loader.sv - directed self-checking bench with a FIFO model and a write-data scoreboard
module tb_sr_config_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  div = 6'd2;
    logic [15:0] cmd_fifo_dout = 16'h0;
    logic        cmd_fifo_empty = 1'b1;
    logic        cmd_fifo_rd_en;
    logic        sr_wr_en;
    logic [15:0] sr_din;
    logic        sr_start;
    logic        sr_valid = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int last_wr_cyc = -100;
    int mon_errs = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];

    sr_config_loader #(.TIMEOUT_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .go             (go),
        .abort          (abort),
        .div            (div),
        .cmd_fifo_dout  (cmd_fifo_dout),
        .cmd_fifo_empty (cmd_fifo_empty),
        .cmd_fifo_rd_en (cmd_fifo_rd_en),
        .sr_wr_en       (sr_wr_en),
        .sr_din         (sr_din),
        .sr_start       (sr_start),
        .sr_valid       (sr_valid),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Standard FIFO: data appears the cycle after rd_en
    always @(posedge clk) begin
        if (cmd_fifo_rd_en && fifo_q.size() > 0) cmd_fifo_dout <= fifo_q.pop_front();
        cmd_fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (sr_wr_en) begin
            wr_cnt = wr_cnt + 1;
            if (cyc - last_wr_cyc < 2) begin
                mon_errs = mon_errs + 1;
                $display("FAIL wr_spacing gap=%0d required>=2", cyc - last_wr_cyc);
            end
            if (exp_q.size() == 0) begin
                mon_errs = mon_errs + 1;
                $display("FAIL wr_unexpected sr_din=%h required=no write", sr_din);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (sr_din !== e) begin
                    mon_errs = mon_errs + 1;
                    $display("FAIL sr_din observed=%h required=%h", sr_din, e);
                end
            end
            last_wr_cyc = cyc;
        end
        if (cmd_fifo_rd_en && cmd_fifo_empty) begin
            mon_errs = mon_errs + 1;
            $display("FAIL rd_when_empty observed=1 required=0");
        end
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic push_block(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + 16'(i));
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    // which: 0 = sr_start high, 1 = sr_start low, 2 = done high; n = steps taken or -1
    task automatic wait_sig(input int which, input int budget, output int n);
        n = -1;
        for (int i = 0; i <= budget; i++) begin
            if ((which == 0 && sr_start) || (which == 1 && !sr_start) || (which == 2 && done)) begin
                n = i;
                break;
            end
            step();
        end
    endtask

    task automatic run_finish(input string tag);
        int n;
        wait_sig(0, 300, n);
        chk({tag, "_start_seen"}, 32'(n >= 0), 1);
        wait_sig(1, 300, n);
        chk({tag, "_start_end"}, 32'(n >= 0), 1);
        repeat (5) step();
        sr_valid = 1'b1;
        wait_sig(2, 50, n);
        chk({tag, "_done_seen"}, 32'(n >= 0), 1);
        step();
        sr_valid = 1'b0;
    endtask

    initial begin
        int g;
        int n;
        int v;
        int w0;
        int d0;

        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {cmd_fifo_rd_en, sr_wr_en, sr_start, done, timeout}, 0);
        chk("rst_din", sr_din, 0);
        rst = 1'b0;
        step();

        // Full transaction, div=2, valid 40 clk into WAIT
        push_block(16'h0001, 11);
        step();
        w0 = wr_cnt;
        g = cyc;
        pulse_go();
        chk("t1_busy", busy, 1);
        wait_sig(0, 100, n);
        chk("t1_start_cyc", cyc, g + 23);
        chk("t1_last_wr_cyc", last_wr_cyc, g + 22);
        chk("t1_wr_count", wr_cnt - w0, 11);
        wait_sig(1, 100, n);
        chk("t1_start_len", n, 8);
        repeat (39) step();
        sr_valid = 1'b1;
        v = cyc;
        wait_sig(2, 20, n);
        chk("t1_done_lat", cyc - v, 3);
        chk("t1_timeout", timeout, 0);
        step();
        chk("t1_busy_after", {busy, done}, 0);
        chk("t1_din_hold", sr_din, 16'h000B);
        sr_valid = 1'b0;
        chk("t1_scoreboard", mon_errs, 0);

        // FIFO underrun stalls in FETCH, then completes
        push_block(16'h0020, 5);
        step();
        w0 = wr_cnt;
        pulse_go();
        repeat (20) step();
        chk("t2_partial_wr", wr_cnt - w0, 5);
        chk("t2_stall", {busy, cmd_fifo_rd_en, sr_start}, 3'b100);
        push_block(16'h0025, 6);
        run_finish("t2");
        chk("t2_wr_count", wr_cnt - w0, 11);
        chk("t2_timeout", timeout, 0);

        // No readback: timeout after 255 WAIT cycles
        push_block(16'h0030, 11);
        step();
        pulse_go();
        wait_sig(0, 100, n);
        wait_sig(1, 100, n);
        wait_sig(2, 400, n);
        chk("t3_wait_len", n, 255);
        chk("t3_timeout", timeout, 1);
        repeat (10) step();
        chk("t3_sticky", timeout, 1);
        chk("t3_idle", busy, 0);

        // Abort in the 4th CAPTURE
        push_block(16'h0040, 11);
        step();
        w0 = wr_cnt;
        pulse_go();
        chk("t4_timeout_clr", timeout, 0);
        for (int i = 0; i < 40 && wr_cnt - w0 < 4; i++) step();
        chk("t4_in_capture", sr_wr_en, 1);
        d0 = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_after_abort", {sr_wr_en, busy, done, cmd_fifo_rd_en}, 0);
        repeat (5) step();
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_wr_count", wr_cnt - w0, 4);
        fifo_q.delete();
        exp_q.delete();
        repeat (2) step();
        push_block(16'h0050, 11);
        step();
        w0 = wr_cnt;
        pulse_go();
        run_finish("t4b");
        chk("t4b_wr_count", wr_cnt - w0, 11);
        chk("t4b_scoreboard", mon_errs, 0);

        // go during START and WAIT is ignored
        push_block(16'h0060, 11);
        step();
        d0 = done_cnt;
        pulse_go();
        wait_sig(0, 100, n);
        step();
        pulse_go();
        wait_sig(1, 100, n);
        repeat (3) step();
        pulse_go();
        repeat (3) step();
        sr_valid = 1'b1;
        wait_sig(2, 50, n);
        sr_valid = 1'b0;
        repeat (30) step();
        chk("t5_one_done", done_cnt - d0, 1);
        chk("t5_idle", busy, 0);

        // Asynchronous reset during START
        push_block(16'h0070, 11);
        step();
        pulse_go();
        wait_sig(0, 100, n);
        repeat (2) step();
        chk("t6_in_start", sr_start, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_rst", {sr_start, busy, cmd_fifo_rd_en, sr_wr_en}, 0);
        step();
        rst = 1'b0;
        step();
        chk("t6_idle", busy, 0);
        push_block(16'h0080, 11);
        step();
        w0 = wr_cnt;
        pulse_go();
        chk("t6_go_busy", busy, 1);
        run_finish("t6");
        chk("t6_wr_count", wr_cnt - w0, 11);
        chk("t6_scoreboard", mon_errs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
